// File: rtl/display_pkg.sv
// Shared types and constants for the two-digit Gray-code display scheduler.
package display_pkg;

    // Scheduler states: waiting, one-cycle conversion, and the two display slots.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CONVERT    = 2'd1,
        SHOW_UNITS = 2'd2,
        SHOW_TENS  = 2'd3
    } state_t;

    // Cycles each digit stays lit by default.
    localparam int REFRESH_CYCLES_DEFAULT = 27000;

    // Active-high anode selects: bit0 is the units digit, bit1 is the tens digit.
    localparam logic [1:0] ANODE_OFF   = 2'b00;
    localparam logic [1:0] ANODE_UNITS = 2'b01;
    localparam logic [1:0] ANODE_TENS  = 2'b10;

endpackage

// File: rtl/module_gray_to_bcd.sv
// Combinational Gray-to-binary decode followed by a two-digit BCD split.
module module_gray_to_bcd (
    input  logic [3:0] gray_i,
    output logic [3:0] binary_o,
    output logic [3:0] tens_o,
    output logic [3:0] units_o
);

    logic [3:0] bin;

    // Each binary bit is the previous (higher) binary bit XOR the matching Gray bit.
    always_comb begin
        bin[3] = gray_i[3];
        bin[2] = bin[3] ^ gray_i[2];
        bin[1] = bin[2] ^ gray_i[1];
        bin[0] = bin[1] ^ gray_i[0];
    end

    // Values 10..15 carry a one into the tens digit; subtracting ten cannot wrap there.
    always_comb begin
        binary_o = bin;
        if (bin > 4'd9) begin
            tens_o  = 4'd1;
            units_o = bin - 4'd10;
        end else begin
            tens_o  = 4'd0;
            units_o = bin;
        end
    end

endmodule

// File: rtl/module_display_scheduler.sv
// Accepts a Gray code, converts it once, then multiplexes its two BCD digits
// onto a shared 7-segment decoder with leading-zero blanking on the tens digit.
module module_display_scheduler
    import display_pkg::*;
#(
    parameter int REFRESH_CYCLES = REFRESH_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_i,
    input  logic [3:0] gray_i,
    output logic       ready_o,
    output logic [3:0] digit_o,
    output logic [1:0] anode_o,
    output logic [3:0] value_o
);

    localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       gray_q, gray_d;
    logic [3:0]       value_q, value_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       units_q, units_d;
    logic [3:0]       digit_q, digit_d;
    logic [1:0]       anode_q, anode_d;
    logic             ready_q, ready_d;
    logic             accept;
    logic             slotDone;

    logic [3:0]       convBin;
    logic [3:0]       convTens;
    logic [3:0]       convUnits;

    module_gray_to_bcd u_gray_to_bcd (
        .gray_i   (gray_q),
        .binary_o (convBin),
        .tens_o   (convTens),
        .units_o  (convUnits)
    );

    // Next-state logic: a new code always wins over the running slot, otherwise
    // conversion hands off to the units slot and the two slots alternate.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gray_d   = gray_q;
        value_d  = value_q;
        tens_d   = tens_q;
        units_d  = units_q;
        digit_d  = digit_q;
        anode_d  = anode_q;
        accept   = valid_i && ready_q;
        slotDone = (cnt_q == CNT_LAST);

        if (accept) begin
            gray_d  = gray_i;
            state_d = CONVERT;
            cnt_d   = '0;
            anode_d = ANODE_OFF;
        end else begin
            case (state_q)
                IDLE: begin
                    anode_d = ANODE_OFF;
                end
                CONVERT: begin
                    value_d = convBin;
                    tens_d  = convTens;
                    units_d = convUnits;
                    digit_d = convUnits;
                    anode_d = ANODE_UNITS;
                    cnt_d   = '0;
                    state_d = SHOW_UNITS;
                end
                SHOW_UNITS: begin
                    if (slotDone) begin
                        cnt_d   = '0;
                        state_d = SHOW_TENS;
                        digit_d = tens_q;
                        anode_d = (tens_q != 4'd0) ? ANODE_TENS : ANODE_OFF;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                SHOW_TENS: begin
                    if (slotDone) begin
                        cnt_d   = '0;
                        state_d = SHOW_UNITS;
                        digit_d = units_q;
                        anode_d = ANODE_UNITS;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    anode_d = ANODE_OFF;
                end
            endcase
        end

        ready_d = (state_d != CONVERT);
    end

    // State and registered outputs; reset overrides any acceptance on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gray_q  <= '0;
            value_q <= '0;
            tens_q  <= '0;
            units_q <= '0;
            digit_q <= '0;
            anode_q <= ANODE_OFF;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gray_q  <= gray_d;
            value_q <= value_d;
            tens_q  <= tens_d;
            units_q <= units_d;
            digit_q <= digit_d;
            anode_q <= anode_d;
            ready_q <= ready_d;
        end
    end

    assign ready_o = ready_q;
    assign digit_o = digit_q;
    assign anode_o = anode_q;
    assign value_o = value_q;

endmodule
